// File: rtl/mul_issue_ctrl.sv
// Issue/track/stall/writeback control for a fixed-latency multiply IP.
// A shadow pipeline of valid/op/rd mirrors the IP stages under a shared clock enable.
module mul_issue_ctrl #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned RD_W    = 5,
  parameter int unsigned OP_W    = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               issue_valid_i,
  output logic                               issue_ready_o,
  input  logic [OP_W-1:0]                    issue_op_i,
  input  logic [RD_W-1:0]                    issue_rd_i,
  input  logic                               flush_i,
  output logic                               mul_ce_o,
  output logic [OP_W-1:0]                    mul_op_o,
  output logic                               wb_valid_o,
  input  logic                               wb_ready_i,
  output logic [RD_W-1:0]                    wb_rd_o,
  input  logic [RD_W-1:0]                    rd_check_i,
  output logic                               rd_hazard_o,
  output logic [$clog2(LATENCY+1)-1:0]       inflight_o
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] v_q, v_d;
  logic [OP_W-1:0]    op_q [LATENCY];
  logic [OP_W-1:0]    op_d [LATENCY];
  logic [RD_W-1:0]    rd_q [LATENCY];
  logic [RD_W-1:0]    rd_d [LATENCY];

  logic stall;
  logic accept;

  // A tail result that writeback will not take freezes the whole IP.
  assign stall         = v_q[LATENCY-1] & ~wb_ready_i;
  assign mul_ce_o      = ~stall;
  assign issue_ready_o = ~stall & ~flush_i & ~rst_i;
  assign accept        = issue_valid_i & issue_ready_o;

  assign wb_valid_o = v_q[LATENCY-1] & ~flush_i;
  assign wb_rd_o    = rd_q[LATENCY-1];
  assign mul_op_o   = op_q[LATENCY-1];

  always_comb begin
    v_d  = v_q;
    op_d = op_q;
    rd_d = rd_q;
    if (mul_ce_o) begin
      v_d[0]  = accept;
      op_d[0] = issue_op_i;
      rd_d[0] = issue_rd_i;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        v_d[k]  = v_q[k-1];
        op_d[k] = op_q[k-1];
        rd_d[k] = rd_q[k-1];
      end
    end
    // Flush only clears valid bits; op/rd contents become don't-care.
    if (flush_i) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q  <= '0;
      op_q <= '{default: '0};
      rd_q <= '{default: '0};
    end else begin
      v_q  <= v_d;
      op_q <= op_d;
      rd_q <= rd_d;
    end
  end

  always_comb begin
    logic hit;
    hit        = 1'b0;
    inflight_o = '0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      inflight_o = inflight_o + CNT_W'(v_q[k]);
      if (v_q[k] && (rd_q[k] == rd_check_i)) begin
        hit = 1'b1;
      end
    end
    rd_hazard_o = hit & (rd_check_i != '0);
  end

endmodule
